arbiter_rr_router: RTL and testbench



---
 rtl/arbiter_rr_router_pkg.sv | 22 ++
 rtl/arbiter_rr_router_if.sv | 16 +
 rtl/arbiter_rr_router_pick.sv | 33 +++
 rtl/arbiter_rr_router.sv | 114 +++++++++++
 tb/tb_arbiter_rr_router.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arbiter_rr_router_pkg.sv
// Shared types and helpers for the router output-port arbiter and its crossbar.
package arbiter_router_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // OR-based encoder; a zero input yields index 0, matching grant_idx when idle.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbiter_rr_router_if.sv
// Request/grant bundle between input-port request logic (master) and the arbiter (slave).
interface arbiter_rr_router_if #(
    parameter int N_REQ = 16
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] request;
    logic [N_REQ-1:0] eop;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             busy;
    logic             timeout;

    modport master (output request, eop, input grant, grant_idx, busy, timeout);
    modport slave  (input request, eop, output grant, grant_idx, busy, timeout);
endinterface

// File: rtl/arbiter_rr_router_pick.sv
// Combinational winner select: round-robin from ptr, or lowest index in fixed mode.
// Zero latency; no handshake, caller samples the result.
module arbiter_rr_pick #(
    parameter int N_REQ = 16,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             fixed_prio,
    output logic             win_vld,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx
);
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   sel_vec;
    logic [IDX_W-1:0]   first_idx;
    logic [IDX_W:0]     sum;

    always_comb begin
        // Rotate so that position 0 of sel_vec is requester ptr, then find first set.
        req_dbl   = {req, req} >> ptr;
        sel_vec   = fixed_prio ? req : req_dbl[N_REQ-1:0];
        win_vld   = |sel_vec;
        first_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (sel_vec[i]) first_idx = IDX_W'(i);
        end
        sum = {1'b0, first_idx} + (fixed_prio ? '0 : {1'b0, ptr});
        if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
        win_idx = sum[IDX_W-1:0];
        win_oh  = win_vld ? (N_REQ'(1) << win_idx) : '0;
    end
endmodule

// File: rtl/arbiter_rr_router.sv
// Packet-hold N-way arbiter (RR or fixed priority) driving the crossbar select; 1-cycle grant, 0-cycle handover.
// Optional ARB_TIMEOUT_EN force-releases a grant held MAX_HOLD cycles and pulses timeout.
module arbiter_rr_router
    import arbiter_router_pkg::*;
#(
    parameter int N_REQ         = 16,
    parameter int PRIORITY_MODE = PRIO_RR,
    parameter int MAX_HOLD      = 64,
    localparam int IDX_W        = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              reset,
    arbiter_rr_router_if.slave arb
);
    if (N_REQ < 2 || N_REQ > 32) begin : g_bad_nreq
        $error("arbiter_rr_router: N_REQ must be in 2..32");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_hold
        $error("arbiter_rr_router: MAX_HOLD must be in 2..65535");
    end

    localparam logic FIXED = (PRIORITY_MODE == PRIO_FIXED);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             holder_rel;
    logic             force_rel;
    logic             arbitrate;
    logic             win_vld;
    logic [N_REQ-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;

    arbiter_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req        (arb.request),
        .ptr        (ptr_q),
        .fixed_prio (FIXED),
        .win_vld    (win_vld),
        .win_oh     (win_oh),
        .win_idx    (win_idx)
    );

    // grant_q is one-hot in GRANT, so masking picks out the holder's own bits.
    assign holder_rel = ~|(arb.request & grant_q) | (|(arb.eop & grant_q));

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] hold_q;
    logic             timeout_q;

    assign force_rel = (state_q == GRANT) && !holder_rel && (hold_q == CNT_W'(MAX_HOLD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if (arbitrate && win_vld)  hold_q <= CNT_W'(1);
            else if (arbitrate)        hold_q <= '0;
            else if (state_q == GRANT) hold_q <= hold_q + CNT_W'(1);
        end
    end
    assign arb.timeout = timeout_q;
`else
    assign force_rel   = 1'b0;
    assign arb.timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        arbitrate = 1'b0;
        case (state_q)
            IDLE:    arbitrate = 1'b1;
            GRANT:   arbitrate = holder_rel | force_rel;
            default: arbitrate = 1'b1;
        endcase
        // The holder sits just before ptr, so a still-requesting releaser is searched last.
        if (arbitrate) begin
            if (win_vld) begin
                state_d = GRANT;
                grant_d = win_oh;
                idx_d   = win_idx;
                ptr_d   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            end else begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign arb.grant     = grant_q;
    assign arb.grant_idx = idx_q;
    assign arb.busy      = |grant_q;
endmodule

// File: tb/tb_arbiter_rr_router.sv
// Bench for arbiter_rr_router: RR and fixed-priority instances share stimulus, checked against a queue-free reference model.
module tb_arbiter_rr_router;
    import arbiter_router_pkg::*;

    localparam int N    = 16;
    localparam int MAXH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    arbiter_rr_router_if #(.N_REQ(N)) rr_if ();
    arbiter_rr_router_if #(.N_REQ(N)) fp_if ();

    arbiter_rr_router #(.N_REQ(N), .PRIORITY_MODE(0), .MAX_HOLD(MAXH)) dut_rr (
        .clk(clk), .reset(reset), .arb(rr_if.slave));
    arbiter_rr_router #(.N_REQ(N), .PRIORITY_MODE(1), .MAX_HOLD(MAXH)) dut_fp (
        .clk(clk), .reset(reset), .arb(fp_if.slave));

    // Reference model, index 0 = round-robin instance, 1 = fixed priority.
    int h[2];   // holder, -1 when idle
    int l[2];   // last winner
    int c[2];   // cycles the current grant has been visible
    bit to[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            h[k] = -1; l[k] = N - 1; c[k] = 0; to[k] = 1'b0;
        end
    endtask

    // RR: smallest circular distance past the last winner; fixed: lowest index.
    function automatic int pick(input int mode, input int last, input logic [N-1:0] r);
        int best, bestd, d;
        best = -1; bestd = N;
        for (int j = 0; j < N; j++) begin
            if (r[4'(j)]) begin
                d = (mode == 1) ? j : (j - last - 1 + 2 * N) % N;
                if (d < bestd) begin bestd = d; best = j; end
            end
        end
        return best;
    endfunction

    task automatic model_step(input int k, input logic [N-1:0] r, input logic [N-1:0] e);
        bit rel;
        int w;
        to[k] = 1'b0;
        if (h[k] < 0) rel = 1'b1;
        else begin
            rel = !r[4'(h[k])] || e[4'(h[k])];
`ifdef ARB_TIMEOUT_EN
            if (!rel && c[k] == MAXH) begin rel = 1'b1; to[k] = 1'b1; end
`endif
        end
        if (!rel) c[k]++;
        else begin
            w = pick(k, l[k], r);
            if (w >= 0) begin h[k] = w; l[k] = w; c[k] = 1; end
            else begin h[k] = -1; c[k] = 0; end
        end
    endtask

    function automatic logic [N-1:0] exp_grant(input int k);
        logic [N-1:0] v;
        v = '0;
        if (h[k] >= 0) v[4'(h[k])] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] exp_idx(input int k);
        return (h[k] >= 0) ? 4'(h[k]) : 4'd0;
    endfunction

    // Drive one cycle of inputs just after a falling edge; return at the next falling edge.
    task automatic apply(input logic [N-1:0] r, input logic [N-1:0] e);
        rr_if.request = r; rr_if.eop = e;
        fp_if.request = r; fp_if.eop = e;
        model_step(0, r, e);
        model_step(1, r, e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rr_if.request = '0; rr_if.eop = '0;
        fp_if.request = '0; fp_if.eop = '0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (!$onehot0(rr_if.grant) || !$onehot0(fp_if.grant)) begin
                failures++;
                $display("FAIL onehot0 rr_grant=%h fp_grant=%h required at most one bit", rr_if.grant, fp_if.grant);
            end
        end
    end

    task automatic test_reset();
        rr_if.request = '0; rr_if.eop = '0;
        fp_if.request = '0; fp_if.eop = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rr_if.grant !== '0) begin failures++; $display("FAIL reset_grant got=%h want=0", rr_if.grant); end
        checks++; if (rr_if.grant_idx !== '0) begin failures++; $display("FAIL reset_idx got=%0d want=0", rr_if.grant_idx); end
        checks++; if (rr_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", rr_if.busy); end
        checks++; if (rr_if.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b want=0", rr_if.timeout); end
        checks++; if (fp_if.grant !== '0) begin failures++; $display("FAIL reset_fp_grant got=%h want=0", fp_if.grant); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_handover();
        do_reset();
        apply(16'h0005, 16'h0000);
        checks++; if (rr_if.grant !== 16'h0001) begin failures++; $display("FAIL basic_grant got=%h want=0001", rr_if.grant); end
        checks++; if (rr_if.grant_idx !== 4'd0) begin failures++; $display("FAIL basic_idx got=%0d want=0", rr_if.grant_idx); end
        checks++; if (rr_if.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", rr_if.busy); end
        apply(16'h0005, 16'h0001);
        checks++; if (rr_if.grant !== 16'h0004) begin failures++; $display("FAIL handover_grant got=%h want=0004", rr_if.grant); end
        checks++; if (rr_if.grant_idx !== 4'd2) begin failures++; $display("FAIL handover_idx got=%0d want=2", rr_if.grant_idx); end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int k = 0; k <= N; k++) begin
            apply(16'hFFFF, 16'hFFFF);
            checks++;
            if (rr_if.grant_idx !== 4'(k % N) || rr_if.busy !== 1'b1) begin
                failures++;
                $display("FAIL rotation step=%0d got_idx=%0d busy=%b want_idx=%0d busy=1", k, rr_if.grant_idx, rr_if.busy, k % N);
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        apply(16'h8001, 16'h0000);
        checks++; if (fp_if.grant !== 16'h0001) begin failures++; $display("FAIL fixed_first got=%h want=0001", fp_if.grant); end
        for (int i = 0; i < 20; i++) begin
            apply(16'h8001, 16'h0001);
            checks++;
            if (fp_if.grant !== 16'h0001) begin failures++; $display("FAIL fixed_starve step=%0d got=%h want=0001", i, fp_if.grant); end
        end
    endtask

    task automatic test_drop_to_idle();
        do_reset();
        apply(16'h0008, 16'h0000);
        checks++; if (rr_if.grant !== 16'h0008 || rr_if.grant_idx !== 4'd3) begin failures++; $display("FAIL drop_first got=%h/%0d want=0008/3", rr_if.grant, rr_if.grant_idx); end
        apply(16'h0008, 16'h0000);
        checks++; if (rr_if.grant !== 16'h0008) begin failures++; $display("FAIL drop_hold got=%h want=0008", rr_if.grant); end
        apply(16'h0000, 16'h0000);
        checks++; if (rr_if.grant !== '0 || rr_if.busy !== 1'b0 || rr_if.grant_idx !== '0) begin failures++; $display("FAIL drop_idle got=%h busy=%b idx=%0d want=0 0 0", rr_if.grant, rr_if.busy, rr_if.grant_idx); end
        apply(16'h0002, 16'h0000);
        checks++; if (rr_if.grant !== 16'h0002) begin failures++; $display("FAIL idle_regrant got=%h want=0002", rr_if.grant); end
        apply(16'h000A, 16'h0008);
        checks++; if (rr_if.grant !== 16'h0002) begin failures++; $display("FAIL foreign_eop got=%h want=0002", rr_if.grant); end
        apply(16'h0008, 16'h0002);
        checks++; if (rr_if.grant !== 16'h0008) begin failures++; $display("FAIL eop_and_drop got=%h want=0008", rr_if.grant); end
    endtask

    task automatic test_async_reset();
        do_reset();
        apply(16'h0010, 16'h0000);
        checks++; if (rr_if.grant !== 16'h0010) begin failures++; $display("FAIL pre_reset got=%h want=0010", rr_if.grant); end
        #2 reset = 1'b1;
        #1;
        checks++; if (rr_if.grant !== '0 || rr_if.busy !== 1'b0) begin failures++; $display("FAIL async_reset got=%h busy=%b want=0 0", rr_if.grant, rr_if.busy); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        apply(16'h0041, 16'h0000);
        checks++; if (rr_if.grant !== 16'h0001) begin failures++; $display("FAIL ptr_cleared got=%h want=0001", rr_if.grant); end
        apply(16'h0010, 16'h0000);
        checks++; if (rr_if.grant !== 16'h0010) begin failures++; $display("FAIL post_reset got=%h want=0010", rr_if.grant); end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        apply(16'h0004, 16'h0000);
        for (int i = 0; i < MAXH - 1; i++) begin
            apply(16'h0024, 16'h0000);
            checks++;
            if (rr_if.grant !== 16'h0004 || rr_if.timeout !== 1'b0) begin failures++; $display("FAIL timeout_hold step=%0d got=%h to=%b want=0004 0", i, rr_if.grant, rr_if.timeout); end
        end
        apply(16'h0024, 16'h0000);
        checks++; if (rr_if.grant !== 16'h0020 || rr_if.timeout !== 1'b1) begin failures++; $display("FAIL timeout_fire got=%h to=%b want=0020 1", rr_if.grant, rr_if.timeout); end
        apply(16'h0020, 16'h0000);
        checks++; if (rr_if.timeout !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b want=0", rr_if.timeout); end
    endtask
`else
    task automatic test_timeout();
        do_reset();
        apply(16'h0004, 16'h0000);
        for (int i = 0; i < 3 * MAXH; i++) begin
            apply(16'h0024, 16'h0000);
            checks++;
            if (rr_if.grant !== 16'h0004 || rr_if.timeout !== 1'b0) begin failures++; $display("FAIL no_timeout step=%0d got=%h to=%b want=0004 0", i, rr_if.grant, rr_if.timeout); end
        end
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] want, ev;
        logic [N-1:0] gq[2];
        logic [3:0]   iq[2];
        logic         bq[2], tq[2];
        do_reset();
        want = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) want[4'(b)] = ~want[4'(b)];
                ev[4'(b)] = ($urandom_range(3) == 0);
            end
            apply(want, ev);
            gq[0] = rr_if.grant; iq[0] = rr_if.grant_idx; bq[0] = rr_if.busy; tq[0] = rr_if.timeout;
            gq[1] = fp_if.grant; iq[1] = fp_if.grant_idx; bq[1] = fp_if.busy; tq[1] = fp_if.timeout;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (gq[k] !== exp_grant(k)) begin failures++; $display("FAIL rand_grant dut=%0d cyc=%0d got=%h want=%h", k, cyc, gq[k], exp_grant(k)); end
                checks++;
                if (iq[k] !== exp_idx(k) || onehot_to_idx(32'(gq[k])) !== 5'(exp_idx(k))) begin failures++; $display("FAIL rand_idx dut=%0d cyc=%0d got=%0d want=%0d", k, cyc, iq[k], exp_idx(k)); end
                checks++;
                if (bq[k] !== (h[k] >= 0) || tq[k] !== to[k]) begin failures++; $display("FAIL rand_busy_to dut=%0d cyc=%0d got=%b/%b want=%b/%b", k, cyc, bq[k], tq[k], h[k] >= 0, to[k]); end
            end
        end
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic_handover();
        test_rotation();
        test_fixed_priority();
        test_drop_to_idle();
        test_async_reset();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
